// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared types and constants for the APB timer counter control.
//               Holds the control FSM state encoding, the prescaler exponent
//               limit and the TCR field positions used by the register block.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Counter-control FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } ctrl_state_t;

    // Largest legal TCR.div_val; larger programmed values are clamped
    localparam int c_max_div_val = 8;

    // TCR field positions, shared with the register block
    localparam int c_tcr_timer_en_bit = 0;
    localparam int c_tcr_div_en_bit   = 1;
    localparam int c_tcr_div_val_lsb  = 8;
    localparam int c_tcr_div_val_msb  = 11;

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : timer_prescaler
// Description : Clock prescaler for the timer counter. Counts int_cnt up to
//               2^e - 1 (e = clamped divide exponent) and flags the tick.
//               The count restarts whenever the divider setting changes
//               while running, and freezes while the timer is halted.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int MAX_DIV_VAL = c_max_div_val
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       freeze,
    input  logic       div_en,
    input  logic [3:0] div_val,
    output logic       tick
);

    logic             r_div_en_q;
    logic [3:0]       r_div_val_q;
    logic [DIV_W-1:0] r_int_cnt;
    logic [3:0]       w_exp;
    logic [DIV_W-1:0] w_limit;
    logic             w_cfg_chg;

    // Effective divide exponent from the registered divider setting, clamped
    always_comb begin
        w_exp = 4'd0;
        if (r_div_en_q && (r_div_val_q != 4'd0)) begin
            if (32'(r_div_val_q) > MAX_DIV_VAL) begin
                w_exp = 4'(MAX_DIV_VAL);
            end else begin
                w_exp = r_div_val_q;
            end
        end
    end

    // 2^e - 1 built as a mask so e == DIV_W still fits in DIV_W bits
    assign w_limit   = ~({DIV_W{1'b1}} << w_exp);
    assign tick      = (r_int_cnt == w_limit);
    assign w_cfg_chg = (div_en != r_div_en_q) || (div_val != r_div_val_q);

    // Divider copies follow the inputs every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_en_q  <= 1'b0;
            r_div_val_q <= 4'd1;
        end else begin
            r_div_en_q  <= div_en;
            r_div_val_q <= div_val;
        end
    end

    // Prescale count: clear when idle or reconfigured, wrap on tick, hold when frozen.
    // A tick that coincides with halt entry has already been delivered, so
    // the count wraps rather than holding at the terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_cnt <= '0;
        end else if (!run && !freeze) begin
            r_int_cnt <= '0;
        end else if (run && w_cfg_chg) begin
            r_int_cnt <= '0;
        end else if (run && tick) begin
            r_int_cnt <= '0;
        end else if (!freeze) begin
            r_int_cnt <= r_int_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/timer_cnt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : timer_cnt_ctrl
// Description : Counter-control block for the APB timer. Sequences the
//               IDLE/RUN/HALTED states from TCR.timer_en and the debug halt
//               request, and issues the single-cycle count-enable tick.
//               Build option TIMER_CTRL_HALT_EN adds the debug-halt state and
//               halt_ack handshake; without it halt_req/dbg_mode are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_cnt_ctrl
    import timer_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int MAX_DIV_VAL = c_max_div_val
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       timer_en,
    input  logic       div_en,
    input  logic [3:0] div_val,
    input  logic       halt_req,
    input  logic       dbg_mode,
    output logic       cnt_en,
    output logic       halt_ack,
    output logic [1:0] ctrl_state
);

    ctrl_state_t r_state;
    ctrl_state_t w_next_state;
    logic        w_halt_entry;
    logic        w_tick;

    // Next-state logic; timer_en low always wins
    always_comb begin
        w_next_state = r_state;
        w_halt_entry = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (timer_en) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!timer_en) begin
                    w_next_state = ST_IDLE;
                end
`ifdef TIMER_CTRL_HALT_EN
                else if (halt_req && dbg_mode) begin
                    w_next_state = ST_HALTED;
                    w_halt_entry = 1'b1;
                end
`endif
            end
`ifdef TIMER_CTRL_HALT_EN
            ST_HALTED: begin
                if (!timer_en) begin
                    w_next_state = ST_IDLE;
                end else if (!halt_req || !dbg_mode) begin
                    w_next_state = ST_RUN;
                end
            end
`endif
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    timer_prescaler #(
        .DIV_W       (DIV_W),
        .MAX_DIV_VAL (MAX_DIV_VAL)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (r_state == ST_RUN),
        .freeze  ((r_state == ST_HALTED) || w_halt_entry),
        .div_en  (div_en),
        .div_val (div_val),
        .tick    (w_tick)
    );

    assign cnt_en     = (r_state == ST_RUN) && w_tick;
    assign ctrl_state = r_state;

`ifdef TIMER_CTRL_HALT_EN
    logic r_halt_ack;

    // Ack rises one cycle after entering HALTED and drops on the exit edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halt_ack <= 1'b0;
        end else begin
            r_halt_ack <= (r_state == ST_HALTED) && (w_next_state == ST_HALTED);
        end
    end

    assign halt_ack = r_halt_ack;
`else
    logic w_halt_unused;
    assign w_halt_unused = halt_req ^ dbg_mode;
    assign halt_ack      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_timer_cnt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_cnt_ctrl
// Description : Directed self-checking bench for timer_cnt_ctrl. Halt
//               handshake scenarios are selected by TIMER_CTRL_HALT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_timer_cnt_ctrl;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       timer_en = 1'b0;
    logic       div_en   = 1'b0;
    logic [3:0] div_val  = 4'd0;
    logic       halt_req = 1'b0;
    logic       dbg_mode = 1'b0;
    logic       cnt_en;
    logic       halt_ack;
    logic [1:0] ctrl_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    timer_cnt_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .timer_en   (timer_en),
        .div_en     (div_en),
        .div_val    (div_val),
        .halt_req   (halt_req),
        .dbg_mode   (dbg_mode),
        .cnt_en     (cnt_en),
        .halt_ack   (halt_ack),
        .ctrl_state (ctrl_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        timer_en = 1'b0;
        halt_req = 1'b0;
        dbg_mode = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (cnt_en !== 1'b0 || halt_ack !== 1'b0 || ctrl_state !== 2'b00) begin
            failures++;
            $display("FAIL reset cnt_en=%b halt_ack=%b state=%b expected 0 0 00", cnt_en, halt_ack, ctrl_state);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (ctrl_state !== 2'b00 || cnt_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_release state=%b cnt_en=%b expected 00 0", ctrl_state, cnt_en);
        end
    endtask

    task automatic test_no_div();
        div_en   = 1'b0;
        div_val  = 4'd5;
        timer_en = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (cnt_en !== 1'b1 || ctrl_state !== 2'b01) begin
                failures++;
                $display("FAIL no_div idx=%0d cnt_en=%b state=%b expected 1 01", i, cnt_en, ctrl_state);
            end
            step();
        end
        timer_en = 1'b0;
        step();
        checks++;
        if (cnt_en !== 1'b0 || ctrl_state !== 2'b00) begin
            failures++;
            $display("FAIL no_div_stop cnt_en=%b state=%b expected 0 00", cnt_en, ctrl_state);
        end
        div_en  = 1'b1;
        div_val = 4'd0;
        step();
        timer_en = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cnt_en !== 1'b1) begin
                failures++;
                $display("FAIL div_val0 idx=%0d cnt_en=%b expected 1", i, cnt_en);
            end
            step();
        end
        go_idle();
    endtask

    task automatic test_div3();
        div_en  = 1'b1;
        div_val = 4'd3;
        step();
        timer_en = 1'b1;
        step();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (cnt_en !== ((i % 8) == 7)) begin
                failures++;
                $display("FAIL div3 idx=%0d cnt_en=%b expected %b", i, cnt_en, ((i % 8) == 7));
            end
            step();
        end
        go_idle();
    endtask

    task automatic test_clamp();
        div_en  = 1'b1;
        div_val = 4'hF;
        step();
        timer_en = 1'b1;
        step();
        for (int i = 0; i < 512; i++) begin
            checks++;
            if (cnt_en !== ((i % 256) == 255)) begin
                failures++;
                $display("FAIL clamp idx=%0d cnt_en=%b expected %b", i, cnt_en, ((i % 256) == 255));
            end
            step();
        end
        go_idle();
    endtask

    task automatic test_cfg_change();
        logic exp_en;
        div_en  = 1'b1;
        div_val = 4'd2;
        step();
        timer_en = 1'b1;
        step();
        for (int i = 0; i < 13; i++) begin
            exp_en = (i == 3) || (i == 7) || (i == 9) || (i == 11);
            checks++;
            if (cnt_en !== exp_en) begin
                failures++;
                $display("FAIL cfg_change idx=%0d cnt_en=%b expected %b", i, cnt_en, exp_en);
            end
            if (i == 5) div_val = 4'd1;
            step();
        end
        go_idle();
    endtask

    task automatic test_halt_ignored(input logic dbg);
        div_en  = 1'b1;
        div_val = 4'd2;
        step();
        timer_en = 1'b1;
        step();
        halt_req = 1'b1;
        dbg_mode = dbg;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (cnt_en !== ((i % 4) == 3) || ctrl_state !== 2'b01 || halt_ack !== 1'b0) begin
                failures++;
                $display("FAIL halt_ignored dbg=%b idx=%0d cnt_en=%b state=%b ack=%b expected %b 01 0",
                         dbg, i, cnt_en, ctrl_state, halt_ack, ((i % 4) == 3));
            end
            step();
        end
        go_idle();
    endtask

`ifdef TIMER_CTRL_HALT_EN
    task automatic test_halt();
        logic exp_en;
        div_en  = 1'b1;
        div_val = 4'd2;
        step();
        timer_en = 1'b1;
        step();
        step();
        // int_cnt is 1 here
        halt_req = 1'b1;
        dbg_mode = 1'b1;
        step();
        checks++;
        if (ctrl_state !== 2'b10 || halt_ack !== 1'b0 || cnt_en !== 1'b0) begin
            failures++;
            $display("FAIL halt_entry state=%b ack=%b cnt_en=%b expected 10 0 0", ctrl_state, halt_ack, cnt_en);
        end
        for (int i = 3; i < 6; i++) begin
            step();
            checks++;
            if (ctrl_state !== 2'b10 || halt_ack !== 1'b1 || cnt_en !== 1'b0) begin
                failures++;
                $display("FAIL halted idx=%0d state=%b ack=%b cnt_en=%b expected 10 1 0", i, ctrl_state, halt_ack, cnt_en);
            end
        end
        halt_req = 1'b0;
        step();
        checks++;
        if (ctrl_state !== 2'b01 || halt_ack !== 1'b0) begin
            failures++;
            $display("FAIL halt_exit state=%b ack=%b expected 01 0", ctrl_state, halt_ack);
        end
        for (int i = 6; i < 13; i++) begin
            exp_en = (i == 8) || (i == 12);
            checks++;
            if (cnt_en !== exp_en) begin
                failures++;
                $display("FAIL halt_resume idx=%0d cnt_en=%b expected %b", i, cnt_en, exp_en);
            end
            if (i < 12) step();
        end
        halt_req = 1'b1;
        step();
        step();
        checks++;
        if (ctrl_state !== 2'b10 || halt_ack !== 1'b1) begin
            failures++;
            $display("FAIL halt_again state=%b ack=%b expected 10 1", ctrl_state, halt_ack);
        end
        timer_en = 1'b0;
        halt_req = 1'b0;
        step();
        checks++;
        if (ctrl_state !== 2'b00 || halt_ack !== 1'b0 || cnt_en !== 1'b0) begin
            failures++;
            $display("FAIL halt_disable state=%b ack=%b cnt_en=%b expected 00 0 0", ctrl_state, halt_ack, cnt_en);
        end
        timer_en = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cnt_en !== (i == 3)) begin
                failures++;
                $display("FAIL halt_restart idx=%0d cnt_en=%b expected %b", i, cnt_en, (i == 3));
            end
            step();
        end
        go_idle();
    endtask
`endif

    task automatic test_reset_mid();
        div_en   = 1'b0;
        timer_en = 1'b1;
        step();
        step();
        checks++;
        if (cnt_en !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset cnt_en=%b expected 1", cnt_en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (cnt_en !== 1'b0 || ctrl_state !== 2'b00 || halt_ack !== 1'b0) begin
            failures++;
            $display("FAIL async_reset cnt_en=%b state=%b ack=%b expected 0 00 0", cnt_en, ctrl_state, halt_ack);
        end
        timer_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (ctrl_state !== 2'b00) begin
            failures++;
            $display("FAIL post_reset state=%b expected 00", ctrl_state);
        end
    endtask

    initial begin
        test_reset();
        test_no_div();
        test_div3();
        test_clamp();
        test_cfg_change();
        test_halt_ignored(1'b0);
`ifdef TIMER_CTRL_HALT_EN
        test_halt();
`else
        test_halt_ignored(1'b1);
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
